iiitb_cg_ctrl: RTL and testbench
================================

// Module: iiitb_cg_ctrl
// PURPOSE
//  Clock-gating controller sitting in front of an integrated clock-gate cell.
//  Arbitrates N requesters that need a gated register bank clocked and applies
//  wake-up settling and idle-timeout hysteresis. Drives a glitch-free gated
//  clock and counts gated-off cycles for power statistics.
// PARAMETERS
//  N_REQ        4   number of requesters (>=1)
//  WAKE_CYCLES  2   settling cycles after enable before grant (>=1)
//  IDLE_CYCLES  8   idle cycles clock stays on after last request (>=0)
//  CNT_W        16  width of gated-off cycle counter
// PORTS
//  clk        in   1      free-running clock
//  rst_n      in   1      asynchronous, active-low reset
//  req        in   N_REQ  per-requester clock request, level
//  force_on   in   1      keep clock on regardless of requests
//  cnt_clr    in   1      synchronous clear of off_cycles
//  ack        out  N_REQ  clock running and stable for this requester
//  cg_en      out  1      registered enable to the ICG cell
//  gclk       out  1      gated clock (clk AND negedge-latched cg_en)
//  state      out  2      current FSM state
//  off_cycles out  CNT_W  cycles spent in OFF, saturating
// BEHAVIOUR
//  Reset: state=OFF, cg_en=0, ack=0, gclk=0, off_cycles=0, timers=0.
//  any = |req | force_on. All state changes happen on posedge clk.
//  OFF : any -> WAKE, load wake timer with WAKE_CYCLES-1. Otherwise stay.
//  WAKE: runs to completion even if any drops. Timer==0 -> ON, else decrement.
//  ON  : !any -> COOL, load idle timer with IDLE_CYCLES-1.
//        With IDLE_CYCLES=0, ON goes straight to OFF.
//  COOL: any -> ON (no wake penalty). Timer==0 -> OFF, else decrement.
//  cg_en = registered (next_state != OFF). It rises in the same cycle WAKE is
//   entered and falls in the same cycle OFF is entered.
//  ack[i] = req[i] & (state==ON | state==COOL). Combinational from registered
//   state; it is never asserted in OFF or WAKE.
//  Latency: req sampled at edge t -> WAKE at t+1 -> ack at t+1+WAKE_CYCLES.
//  gclk: en_l captures cg_en on negedge clk; gclk = clk & en_l. No partial
//   pulses. First gclk pulse is at the first posedge after cg_en rises.
//  off_cycles: +1 each cycle state==OFF; holds at all-ones.
//   cnt_clr has priority over increment.
//  Simultaneous events:
//   - req drop and new req in the same cycle: any stays high, state unchanged.
//   - force_on alone counts as any; ack stays 0 unless req[i] is high.
//  Reset mid-operation: immediate OFF. cg_en, en_l, gclk, ack and timers clear
//   asynchronously.
// STRUCTURE
//  Package iiitb_cg_pkg:
//   - state encoding localparams OFF=2'b00, WAKE=2'b01, ON=2'b10, COOL=2'b11
//   - timer width function clog2(max(WAKE_CYCLES, IDLE_CYCLES)+1)
//  Sub-module iiitb_cg_cell (in clk, en, rst_n; out gclk):
//   - negedge enable flop plus AND gate
//   - instantiated once here
//  FSM, timers and counter stay in this module.
// TESTING (N_REQ=4, WAKE_CYCLES=2, IDLE_CYCLES=3, CNT_W=4)
//  1. Hold rst_n=0, toggle clk -> cg_en=0, gclk=0, ack=0, state=00,
//     off_cycles=0.
//  2. req=4'b0010 at edge t -> cg_en=1 at t+1; ack=4'b0010 from t+3;
//     gclk pulses from t+2.
//  3. Drop req in ON -> COOL for 3 cycles, then OFF; cg_en=0;
//     gclk has no runt pulse.
//  4. req=4'b0100 on 2nd COOL cycle -> ON next edge, ack=4'b0100 immediately,
//     no WAKE.
//  5. force_on=1, req=0 -> WAKE then ON, ack=0, cg_en held. Deassert ->
//     COOL -> OFF.
//  6. Idle 20 cycles in OFF -> off_cycles saturates at 4'hF.
//     cnt_clr=1 together with an increment -> 0.
//  7. Assert rst_n=0 in mid-WAKE -> state=OFF, cg_en=0 and gclk low at once.

Source files
------------

// File: rtl/iiitb_cg_pkg.sv
// rtl/iiitb_cg_pkg.sv - shared state encoding and timer sizing for the clock-gating controller
package iiitb_cg_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'b00,
      WAKE = 2'b01,
      ON   = 2'b10,
      COOL = 2'b11
   } cg_state_e;

   // One timer serves both the wake and idle countdowns, so size it for the larger load.
   function automatic int timer_w(input int wake_cycles, input int idle_cycles);
      int m;
      m = (wake_cycles > idle_cycles) ? wake_cycles : idle_cycles;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/iiitb_cg_cell.sv
// rtl/iiitb_cg_cell.sv - latch-style clock gate: enable captured on negedge, ANDed with clk
module iiitb_cg_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic gclk
);

   logic en_l_q;

   // Capturing on the falling edge keeps the enable stable through the whole high phase.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) en_l_q <= 1'b0;
      else        en_l_q <= en;
   end

   assign gclk = clk & en_l_q;

endmodule

// File: rtl/iiitb_cg_ctrl.sv
// rtl/iiitb_cg_ctrl.sv - clock-gating controller: request arbitration, wake settling, idle hysteresis
module iiitb_cg_ctrl
   import iiitb_cg_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int WAKE_CYCLES = 2,
   parameter int IDLE_CYCLES = 8,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             force_on,
   input  logic             cnt_clr,
   output logic [N_REQ-1:0] ack,
   output logic             cg_en,
   output logic             gclk,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] off_cycles
);

   localparam int TW = timer_w(WAKE_CYCLES, IDLE_CYCLES);
   localparam logic [TW-1:0] WAKE_LOAD = TW'(WAKE_CYCLES - 1);
   localparam logic [TW-1:0] IDLE_LOAD = (IDLE_CYCLES > 0) ? TW'(IDLE_CYCLES - 1) : '0;

   cg_state_e        state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [CNT_W-1:0] off_q, off_d;
   logic             cg_en_q;
   logic             any;
   logic             clk_live;

   assign any = (|req) | force_on;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      unique case (state_q)
         OFF: begin
            if (any) begin
               state_d = WAKE;
               timer_d = WAKE_LOAD;
            end
         end
         WAKE: begin
            if (timer_q == '0) state_d = ON;
            else               timer_d = timer_q - TW'(1);
         end
         ON: begin
            if (!any) begin
               if (IDLE_CYCLES == 0) begin
                  state_d = OFF;
               end else begin
                  state_d = COOL;
                  timer_d = IDLE_LOAD;
               end
            end
         end
         COOL: begin
            // A returning request skips WAKE: the clock never actually stopped.
            if (any)                  state_d = ON;
            else if (timer_q == '0)   state_d = OFF;
            else                      timer_d = timer_q - TW'(1);
         end
         default: state_d = OFF;
      endcase
   end

   always_comb begin
      off_d = off_q;
      if (cnt_clr)                      off_d = '0;
      else if (state_q == OFF && !(&off_q)) off_d = off_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= OFF;
         timer_q <= '0;
         off_q   <= '0;
         cg_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         off_q   <= off_d;
         cg_en_q <= (state_d != OFF);
      end
   end

   assign clk_live   = (state_q == ON) || (state_q == COOL);
   assign ack        = req & {N_REQ{clk_live}};
   assign cg_en      = cg_en_q;
   assign state      = state_q;
   assign off_cycles = off_q;

   iiitb_cg_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (cg_en_q),
      .gclk  (gclk)
   );

endmodule

// File: tb/tb_iiitb_cg_ctrl.sv
// tb/tb_iiitb_cg_ctrl.sv - scoreboard bench for iiitb_cg_ctrl with a behavioural reference model
module tb_iiitb_cg_ctrl;

   localparam int NR = 4;
   localparam int WK = 2;
   localparam int ID = 3;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NR-1:0] req = '0;
   logic          force_on = 1'b0;
   logic          cnt_clr = 1'b0;
   logic [NR-1:0] ack;
   logic          cg_en;
   logic          gclk;
   logic [1:0]    state;
   logic [CW-1:0] off_cycles;

   iiitb_cg_ctrl #(
      .N_REQ       (NR),
      .WAKE_CYCLES (WK),
      .IDLE_CYCLES (ID),
      .CNT_W       (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .force_on   (force_on),
      .cnt_clr    (cnt_clr),
      .ack        (ack),
      .cg_en      (cg_en),
      .gclk       (gclk),
      .state      (state),
      .off_cycles (off_cycles)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]    st;
      logic          en;
      logic [NR-1:0] ack;
      logic [CW-1:0] off;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   logic last_en = 1'b0;

   // Reference model: mode 0=OFF 1=WAKE 2=ON 3=COOL, with elapsed-cycle counters.
   int m_mode = 0;
   int m_wake_done = 0;
   int m_cool_seen = 0;
   int m_off = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_wake_done = 0;
      m_cool_seen = 0;
      m_off = 0;
   endtask

   task automatic drive(input logic [NR-1:0] r, input logic f, input logic c);
      bit   busy;
      int   nxt;
      exp_t x;
      req = r;
      force_on = f;
      cnt_clr = c;
      busy = (r != 0) || f;
      if (c)                m_off = 0;
      else if (m_mode == 0) m_off = (m_off + 1 > 15) ? 15 : m_off + 1;
      nxt = m_mode;
      case (m_mode)
         0: if (busy) begin nxt = 1; m_wake_done = 0; end
         1: begin
            m_wake_done++;
            if (m_wake_done == WK) nxt = 2;
         end
         2: if (!busy) begin
            if (ID == 0) nxt = 0;
            else begin nxt = 3; m_cool_seen = 1; end
         end
         default: begin
            if (busy)                   nxt = 2;
            else if (m_cool_seen == ID) nxt = 0;
            else                        m_cool_seen++;
         end
      endcase
      m_mode = nxt;
      x.st  = 2'(m_mode);
      x.en  = (m_mode != 0);
      x.ack = (m_mode >= 2) ? r : '0;
      x.off = CW'(m_off);
      exp_q.push_back(x);
   endtask

   task automatic step(input logic [NR-1:0] r, input logic f, input logic c);
      @(negedge clk);
      drive(r, f, c);
   endtask

   task automatic release_reset();
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      last_en = 1'b0;
      mon_en = 1'b1;
      drive('0, 1'b0, 1'b0);
   endtask

   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            check("state", int'(state), int'(e.st));
            check("cg_en", int'(cg_en), int'(e.en));
            check("ack", int'(ack), int'(e.ack));
            check("off_cycles", int'(off_cycles), int'(e.off));
            check("gclk_high", int'(gclk), int'(last_en));
            last_en = e.en;
         end
      end
   end

   always @(negedge clk) begin
      #1;
      if (mon_en) check("gclk_low", int'(gclk), 0);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", int'(state), 0);
      check("rst_cg_en", int'(cg_en), 0);
      check("rst_gclk", int'(gclk), 0);
      check("rst_ack", int'(ack), 0);
      check("rst_off", int'(off_cycles), 0);

      release_reset();
      step(4'b0010, 0, 0);
      repeat (5) step(4'b0010, 0, 0);
      repeat (6) step(4'b0000, 0, 0);
      repeat (5) step(4'b1000, 0, 0);
      step(4'b0000, 0, 0);
      step(4'b0000, 0, 0);
      step(4'b0100, 0, 0);
      repeat (3) step(4'b0100, 0, 0);
      step(4'b0001, 0, 0);
      repeat (6) step(4'b0000, 0, 0);
      repeat (6) step(4'b0000, 1, 0);
      repeat (6) step(4'b0000, 0, 0);
      repeat (20) step(4'b0000, 0, 0);
      step(4'b0000, 0, 1);
      repeat (3) step(4'b0000, 0, 0);

      for (int i = 0; i < 400; i++) begin
         logic [NR-1:0] r;
         logic          f;
         r = ($urandom_range(0, 2) == 0) ? '0 : NR'($urandom);
         if ((i / 16) % 3 == 2) r = '0;
         f = ($urandom_range(0, 9) == 0);
         step(r, f, ($urandom_range(0, 19) == 0));
      end

      repeat (10) step(4'b0000, 0, 0);
      step(4'b0001, 0, 0);
      step(4'b0001, 0, 0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      mon_en = 1'b0;
      check("midwake_state", int'(state), 0);
      check("midwake_cg_en", int'(cg_en), 0);
      check("midwake_gclk", int'(gclk), 0);
      check("midwake_ack", int'(ack), 0);
      check("midwake_off", int'(off_cycles), 0);
      exp_q.delete();
      repeat (2) @(posedge clk);

      release_reset();
      for (int i = 0; i < 60; i++) step(NR'($urandom), 0, 0);
      repeat (8) step(4'b0000, 0, 0);
      @(posedge clk);
      #2;
      mon_en = 1'b0;
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
